// File: rtl/dfg_arbiter.sv
// Round-robin arbiter sharing one double-Feynman gate stage (p=a, q=a^b, r=a^c) among N_REQ requesters.
// Define DFG_ARB_PASSES_EN for per-request pass counts; otherwise every request gets exactly one pass.
module dfg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int PASS_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [3*N_REQ-1:0]         req_data,
`ifdef DFG_ARB_PASSES_EN
  input  logic [PASS_W*N_REQ-1:0]    req_passes,
`endif
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2:0]                 rsp_data,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     last_grant_reg;
  logic [ID_W-1:0]     rsp_id_reg;
  logic [2:0]          work_reg;
  logic [PASS_W-1:0]   cnt_reg;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [2:0]          data_arr   [N_REQ];
  logic [PASS_W-1:0]   passes_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[3*gi +: 3];
`ifdef DFG_ARB_PASSES_EN
      assign passes_arr[gi] = req_passes[PASS_W*gi +: PASS_W];
`else
      assign passes_arr[gi] = PASS_W'(1);
`endif
    end
  endgenerate

  // Candidate index (base + off) mod N_REQ; off never exceeds N_REQ, so one wrap suffices.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_found && req_valid[rr_index(last_grant_reg, i)]) begin
        win_found = 1'b1;
        win_id    = rr_index(last_grant_reg, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
`ifdef DFG_ARB_PASSES_EN
          state_next = (passes_arr[win_id] == '0) ? DONE : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN:     if (cnt_reg == PASS_W'(1)) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pointer moves only when a response completes, never at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= ID_W'(N_REQ - 1);
      work_reg       <= '0;
      cnt_reg        <= '0;
      rsp_id_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            work_reg   <= data_arr[win_id];
            cnt_reg    <= passes_arr[win_id];
            rsp_id_reg <= win_id;
          end
        end
        RUN: begin
          work_reg <= {work_reg[2], work_reg[2] ^ work_reg[1], work_reg[2] ^ work_reg[0]};
          cnt_reg  <= cnt_reg - PASS_W'(1);
        end
        DONE:    if (rsp_ready) last_grant_reg <= rsp_id_reg;
        default: ;
      endcase
    end
  end

  // Grant is suppressed during reset so no handshake can complete in that cycle.
  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && win_found && !rst) req_ready[win_id] = 1'b1;
    rsp_valid = (state_reg == DONE);
    rsp_data  = work_reg;
    rsp_id    = rsp_id_reg;
    busy      = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_dfg_arbiter.sv
// Directed bench for dfg_arbiter: reset, single pass, reversibility, fairness, backpressure,
// mid-run reset and an exhaustive data/pass sweep. Pass-count scenarios need DFG_ARB_PASSES_EN.
module tb_dfg_arbiter;
  localparam int N_REQ  = 4;
  localparam int PASS_W = 3;
`ifdef DFG_ARB_PASSES_EN
  localparam int P_HI    = 7;
  localparam int RUN_CYC = 3;
  localparam int MR_PASS = 7;
`else
  localparam int P_HI    = 1;
  localparam int RUN_CYC = 1;
  localparam int MR_PASS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_data;
  logic [11:0] req_passes;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dfg_arbiter #(.N_REQ(N_REQ), .PASS_W(PASS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
`ifdef DFG_ARB_PASSES_EN
    .req_passes(req_passes),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    req_valid  = '0;
    req_data   = '0;
    req_passes = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [2:0] d, input int p);
    req_valid[id]            = 1'b1;
    req_data[3*id +: 3]      = d;
    req_passes[3*id +: 3]    = 3'(p);
  endtask

  function automatic logic [2:0] gate_expect(input logic [2:0] v, input int k);
    return (k % 2 == 1) ? {v[2], v[2] ^ v[1], v[2] ^ v[0]} : v;
  endfunction

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if (rsp_data !== 3'b000) $display("FAIL reset_rsp_data: got %b want 000", rsp_data); else passed++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else passed++;
    $display("reset: outputs idle");
  endtask

  task automatic test_single;
    do_reset();
    set_req(0, 3'b101, 1);
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else passed++;
    tick();
    req_valid = '0;
    #1;
    checks++; if ({rsp_valid, busy} !== 2'b01) $display("FAIL single_t1: got valid/busy %b want 01", {rsp_valid, busy}); else passed++;
    tick();
    checks++; if (rsp_valid !== 1'b1) $display("FAIL single_valid_t2: got %b want 1", rsp_valid); else passed++;
    checks++; if (rsp_data !== 3'b110) $display("FAIL single_data: got %b want 110", rsp_data); else passed++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL single_id: got %0d want 0", rsp_id); else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: got busy %b want 0", busy); else passed++;
    $display("single: req0 101 -> %b id %0d", 3'b110, 0);
  endtask

`ifdef DFG_ARB_PASSES_EN
  task automatic test_reversibility;
    do_reset();
    set_req(2, 3'b111, 2);
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL rev2_grant: got %b want 0100", req_ready); else passed++;
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rev2_early: got %b want 0 at T+2", rsp_valid); else passed++;
    tick();
    checks++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 3'b111, 2'd2})
      $display("FAIL rev2_rsp: got %b want %b", {rsp_valid, rsp_data, rsp_id}, {1'b1, 3'b111, 2'd2}); else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("reversibility: req2 111 passes 2 -> 111");
    set_req(1, 3'b011, 0);
    #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL rev0_grant: got %b want 0010", req_ready); else passed++;
    tick();
    req_valid = '0;
    #1;
    checks++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 3'b011, 2'd1})
      $display("FAIL rev0_rsp: got %b want %b", {rsp_valid, rsp_data, rsp_id}, {1'b1, 3'b011, 2'd1}); else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("reversibility: req1 011 passes 0 -> 011");
  endtask
`endif

  task automatic test_fairness;
    logic [2:0] fair_exp [4];
    logic [3:0] exp_ready;
    int         gid;
    fair_exp = '{3'b001, 3'b010, 3'b011, 3'b111};
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 1);
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 15; c++) begin
      gid = (c / 3) % 4;
      exp_ready = (c % 3 == 0) ? (4'b0001 << gid) : 4'b0000;
      checks++; if (req_ready !== exp_ready)
        $display("FAIL fair_ready_c%0d: got %b want %b", c, req_ready, exp_ready); else passed++;
      if (c % 3 == 2) begin
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(gid), fair_exp[gid]})
          $display("FAIL fair_rsp_c%0d: got %b want %b", c, {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'(gid), fair_exp[gid]});
        else passed++;
        $display("fairness: grant %0d -> %b", gid, rsp_data);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure;
    logic [10:0] exp_hold;
    exp_hold = {1'b1, 3'b111, 2'd3, 1'b1, 4'b0000};
    do_reset();
    set_req(3, 3'b100, 1);
    #1;
    checks++; if (req_ready !== 4'b1000) $display("FAIL bp_grant: got %b want 1000", req_ready); else passed++;
    tick();
    req_valid = '0;
    set_req(0, 3'b001, 1);
    set_req(1, 3'b010, 1);
    tick();
    for (int s = 0; s < 5; s++) begin
      checks++; if ({rsp_valid, rsp_data, rsp_id, busy, req_ready} !== exp_hold)
        $display("FAIL bp_hold_%0d: got %b want %b", s, {rsp_valid, rsp_data, rsp_id, busy, req_ready}, exp_hold);
      else passed++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if ({rsp_valid, rsp_data, rsp_id, busy, req_ready} !== exp_hold)
      $display("FAIL bp_release: got %b want %b", {rsp_valid, rsp_data, rsp_id, busy, req_ready}, exp_hold); else passed++;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++; if ({busy, req_ready} !== 5'b00001)
      $display("FAIL bp_resume: got busy/ready %b want 00001", {busy, req_ready}); else passed++;
    $display("backpressure: req3 100 -> 111 held 5 cycles, req0 next");
    clear_inputs();
  endtask

  task automatic test_midrun_reset;
    logic saw_rsp;
    do_reset();
    set_req(2, 3'b010, 1);
    tick();
    req_valid = '0;
    tick();
    checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd2})
      $display("FAIL mr_prior_rsp: got %b want %b", {rsp_valid, rsp_id}, {1'b1, 2'd2}); else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    set_req(0, 3'b110, MR_PASS);
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL mr_grant: got %b want 0001", req_ready); else passed++;
    tick();
    req_valid = '0;
    for (int r = 1; r < RUN_CYC; r++) tick();
    checks++; if ({busy, rsp_valid} !== 2'b10) $display("FAIL mr_running: got busy/valid %b want 10", {busy, rsp_valid}); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL mr_after_rst: got busy/valid %b want 00", {busy, rsp_valid}); else passed++;
    rsp_ready = 1'b1;
    saw_rsp = 1'b0;
    for (int w = 0; w < 10; w++) begin
      if (rsp_valid === 1'b1 || busy === 1'b1) saw_rsp = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    checks++; if (saw_rsp !== 1'b0) $display("FAIL mr_no_rsp: got activity %b want 0", saw_rsp); else passed++;
    set_req(1, 3'b001, 1);
    set_req(3, 3'b001, 1);
    #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL mr_priority: got %b want 0010", req_ready); else passed++;
    $display("midrun_reset: in-flight dropped, req1 granted first");
    clear_inputs();
  endtask

  task automatic test_exhaustive;
    logic [2:0] exp_d;
    logic [3:0] exp_ready;
    int         id;
    int         lat;
    do_reset();
    for (int k = 1; k <= P_HI; k++) begin
      for (int v = 0; v < 8; v++) begin
        id        = v % 4;
        exp_d     = gate_expect(3'(v), k);
        exp_ready = 4'b0001 << id;
        set_req(id, 3'(v), k);
        #1;
        checks++; if (req_ready !== exp_ready)
          $display("FAIL ex_grant_k%0d_v%0d: got %b want %b", k, v, req_ready, exp_ready); else passed++;
        tick();
        req_valid = '0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 12) begin
          tick();
          lat++;
        end
        checks++; if (lat !== k + 1) $display("FAIL ex_lat_k%0d_v%0d: got %0d want %0d", k, v, lat, k + 1); else passed++;
        checks++; if (rsp_data !== exp_d) $display("FAIL ex_data_k%0d_v%0d: got %b want %b", k, v, rsp_data, exp_d); else passed++;
        checks++; if (rsp_id !== 2'(id)) $display("FAIL ex_id_k%0d_v%0d: got %0d want %0d", k, v, rsp_id, id); else passed++;
        $display("exhaustive: req%0d %b passes %0d -> %b lat %0d", id, 3'(v), k, rsp_data, lat);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
`ifdef DFG_ARB_PASSES_EN
    test_reversibility();
`endif
    test_fairness();
    test_backpressure();
    test_midrun_reset();
    test_exhaustive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
